aq_gemac_rx_crc_check: RTL and testbench

//  Receive-side FCS checker for the GbE MAC RX path, between the GMII byte deframer and the RX buffer.

---
 rtl/aq_gemac_rx_crc_check_if.sv | 41 ++++
 rtl/aq_gemac_rx_crc_check.sv | 193 +++++++++++++++++++
 tb/tb_aq_gemac_rx_crc_check.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_gemac_rx_crc_check_if.sv
// rtl/aq_gemac_rx_crc_check_if.sv - byte, payload and status bundle around the RX FCS checker
//
// Purpose: groups the deframer-side byte stream, the FCS-stripped payload stream and the
//          per-frame status word into one interface.
// Modports:
//   master - frame source / sink side: drives RX_*, observes OUT_* and STAT_*
//   slave  - the FCS checker: consumes RX_*, drives OUT_* and STAT_*
// Signals:
//   RX_VALID/RX_DATA/RX_SOF/RX_EOF/RX_ERR  incoming frame bytes with markers and PHY error
//   OUT_VALID/OUT_DATA/OUT_SOF/OUT_EOF      payload bytes with FCS removed
//   STAT_VALID/STAT_CRC_OK/STAT_LEN_ERR/STAT_PHY_ERR/STAT_LENGTH  one status word per frame
interface aq_gemac_rx_crc_check_if #(
    parameter int LEN_W = 16
);
    logic             RX_VALID;
    logic [7:0]       RX_DATA;
    logic             RX_SOF;
    logic             RX_EOF;
    logic             RX_ERR;
    logic             OUT_VALID;
    logic [7:0]       OUT_DATA;
    logic             OUT_SOF;
    logic             OUT_EOF;
    logic             STAT_VALID;
    logic             STAT_CRC_OK;
    logic             STAT_LEN_ERR;
    logic             STAT_PHY_ERR;
    logic [LEN_W-1:0] STAT_LENGTH;

    modport master (
        output RX_VALID, RX_DATA, RX_SOF, RX_EOF, RX_ERR,
        input  OUT_VALID, OUT_DATA, OUT_SOF, OUT_EOF,
        input  STAT_VALID, STAT_CRC_OK, STAT_LEN_ERR, STAT_PHY_ERR, STAT_LENGTH
    );

    modport slave (
        input  RX_VALID, RX_DATA, RX_SOF, RX_EOF, RX_ERR,
        output OUT_VALID, OUT_DATA, OUT_SOF, OUT_EOF,
        output STAT_VALID, STAT_CRC_OK, STAT_LEN_ERR, STAT_PHY_ERR, STAT_LENGTH
    );
endinterface

// File: rtl/aq_gemac_rx_crc_check.sv
// rtl/aq_gemac_rx_crc_check.sv - GbE MAC receive FCS checker with 4-byte FCS strip
//
// Purpose: runs CRC-32 over each frame (DA..FCS), holds the last 4 bytes in a delay line so the
//          FCS never reaches the payload stream, and emits one status word per frame.
// Ports:
//   CLK  - MAC RX clock
//   RST  - synchronous reset, active high
//   bus  - slave modport: RX_* in, OUT_* payload out, STAT_* status out
module aq_gemac_rx_crc_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    aq_gemac_rx_crc_check_if.slave        bus
);
    localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]      CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0]      CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [LEN_W-1:0] CNT_MAX     = '1;
    localparam logic [LEN_W-1:0] MIN_L       = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L       = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;

    // Byte-wide update, data bits consumed LSB first into a left-shifting register.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // A saturated count means the true length is unknown, so it is always illegal.
    function automatic logic len_bad(input logic [LEN_W-1:0] c);
        return (c < MIN_L) || (c > MAX_L) || (c == CNT_MAX);
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [3:0][7:0]   dl_q, dl_d;       // [0] newest, [3] oldest
    logic [2:0]        fill_q, fill_d;
    logic              phy_q, phy_d;
    logic              first_q, first_d; // next emitted byte is the first payload byte

    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d;
    logic              stat_valid_q, stat_valid_d;
    logic              stat_crc_ok_q, stat_crc_ok_d;
    logic              stat_len_err_q, stat_len_err_d;
    logic              stat_phy_err_q, stat_phy_err_d;
    logic [LEN_W-1:0]  stat_length_q, stat_length_d;

    logic              in_frame;
    logic [31:0]       crc_byte, crc_seed;
    logic [LEN_W-1:0]  cnt_inc;

    always_comb begin
        state_d        = state_q;
        crc_d          = crc_q;
        cnt_d          = cnt_q;
        dl_d           = dl_q;
        fill_d         = fill_q;
        phy_d          = phy_q;
        first_d        = first_q;
        out_valid_d    = 1'b0;
        out_data_d     = 8'h00;
        out_sof_d      = 1'b0;
        out_eof_d      = 1'b0;
        stat_valid_d   = 1'b0;
        stat_crc_ok_d  = stat_crc_ok_q;
        stat_len_err_d = stat_len_err_q;
        stat_phy_err_d = stat_phy_err_q;
        stat_length_d  = stat_length_q;

        in_frame = (state_q != IDLE);
        crc_byte = crc_upd(crc_q, bus.RX_DATA);
        crc_seed = crc_upd(CRC_INIT, bus.RX_DATA);
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        if (in_frame && bus.RX_ERR) phy_d = 1'b1;

        if (bus.RX_VALID && bus.RX_SOF) begin
            if (in_frame) begin
                // Abort: report the old frame as broken; the new one is seeded below.
                stat_valid_d   = 1'b1;
                stat_crc_ok_d  = 1'b0;
                stat_len_err_d = len_bad(cnt_q);
                stat_phy_err_d = 1'b1;
                stat_length_d  = cnt_q;
            end
            crc_d   = crc_seed;
            cnt_d   = LEN_W'(1);
            dl_d    = {24'h0, bus.RX_DATA};
            fill_d  = 3'd1;
            phy_d   = bus.RX_ERR;
            first_d = 1'b1;
            state_d = FILL;
            if (bus.RX_EOF) begin
                // One-byte frame. If it also aborted a frame, the abort status takes the slot.
                if (!in_frame) begin
                    stat_valid_d   = 1'b1;
                    stat_crc_ok_d  = (crc_seed == CRC_RESIDUE);
                    stat_len_err_d = len_bad(LEN_W'(1));
                    stat_phy_err_d = bus.RX_ERR;
                    stat_length_d  = LEN_W'(1);
                end
                state_d = IDLE;
                dl_d    = '0;
                fill_d  = 3'd0;
            end
        end else if (bus.RX_VALID && in_frame) begin
            crc_d = crc_byte;
            cnt_d = cnt_inc;
            dl_d  = {dl_q[2:0], bus.RX_DATA};
            if (state_q == PASS) begin
                out_valid_d = 1'b1;
                out_data_d  = dl_q[3];
                out_sof_d   = first_q;
                out_eof_d   = bus.RX_EOF;
                first_d     = 1'b0;
            end else begin
                fill_d = fill_q + 3'd1;
                if (fill_q == 3'd3) state_d = PASS;
            end
            if (bus.RX_EOF) begin
                stat_valid_d   = 1'b1;
                stat_crc_ok_d  = (crc_byte == CRC_RESIDUE);
                stat_len_err_d = len_bad(cnt_inc);
                stat_phy_err_d = phy_q | bus.RX_ERR;
                stat_length_d  = cnt_inc;
                state_d        = IDLE;
                dl_d           = '0;
                fill_d         = 3'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            crc_q          <= CRC_INIT;
            cnt_q          <= '0;
            dl_q           <= '0;
            fill_q         <= 3'd0;
            phy_q          <= 1'b0;
            first_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 8'h00;
            out_sof_q      <= 1'b0;
            out_eof_q      <= 1'b0;
            stat_valid_q   <= 1'b0;
            stat_crc_ok_q  <= 1'b0;
            stat_len_err_q <= 1'b0;
            stat_phy_err_q <= 1'b0;
            stat_length_q  <= '0;
        end else begin
            state_q        <= state_d;
            crc_q          <= crc_d;
            cnt_q          <= cnt_d;
            dl_q           <= dl_d;
            fill_q         <= fill_d;
            phy_q          <= phy_d;
            first_q        <= first_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_sof_q      <= out_sof_d;
            out_eof_q      <= out_eof_d;
            stat_valid_q   <= stat_valid_d;
            stat_crc_ok_q  <= stat_crc_ok_d;
            stat_len_err_q <= stat_len_err_d;
            stat_phy_err_q <= stat_phy_err_d;
            stat_length_q  <= stat_length_d;
        end
    end

    assign bus.OUT_VALID    = out_valid_q;
    assign bus.OUT_DATA     = out_data_q;
    assign bus.OUT_SOF      = out_sof_q;
    assign bus.OUT_EOF      = out_eof_q;
    assign bus.STAT_VALID   = stat_valid_q;
    assign bus.STAT_CRC_OK  = stat_crc_ok_q;
    assign bus.STAT_LEN_ERR = stat_len_err_q;
    assign bus.STAT_PHY_ERR = stat_phy_err_q;
    assign bus.STAT_LENGTH  = stat_length_q;
endmodule

// File: tb/tb_aq_gemac_rx_crc_check.sv
// tb/tb_aq_gemac_rx_crc_check.sv - randomized self-checking bench for the RX FCS checker
module tb_aq_gemac_rx_crc_check;
    typedef logic [7:0] bq_t[$];
    typedef struct { int cyc; logic sof; logic eof; logic [7:0] data; } out_t;
    typedef struct { int cyc; logic ok; logic len_err; logic phy; logic [15:0] length; } stat_t;

    logic CLK;
    logic RST;
    aq_gemac_rx_crc_check_if #(.LEN_W(16)) bus ();

    aq_gemac_rx_crc_check #(.MIN_LEN(64), .MAX_LEN(1518), .LEN_W(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    bq_t   frm;
    bq_t   frame1;
    bq_t   byte_q;
    int    cyc_q[$];
    out_t  out_q[$];
    stat_t stat_q[$];

    initial begin
        CLK = 1'b0;
        forever #4 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.OUT_VALID)
            out_q.push_back('{cyc: cyc, sof: bus.OUT_SOF, eof: bus.OUT_EOF, data: bus.OUT_DATA});
        if (bus.STAT_VALID)
            stat_q.push_back('{cyc: cyc, ok: bus.STAT_CRC_OK, len_err: bus.STAT_LEN_ERR,
                               phy: bus.STAT_PHY_ERR, length: bus.STAT_LENGTH});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reflected CRC-32 (right shift, 0xEDB88320); a good frame leaves 0xDEBB20E3.
    function automatic logic [31:0] crc_of(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[j]) begin
            c = c ^ {24'h0, q[j]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_frame(input int n, input bit good);
        logic [31:0] fcs;
        int          p;
        frm.delete();
        if (n < 5) begin
            for (int j = 0; j < n; j++) frm.push_back(8'($urandom));
        end else begin
            for (int j = 0; j < n - 4; j++) frm.push_back(8'($urandom));
            fcs = ~crc_of(frm);
            for (int j = 0; j < 4; j++) frm.push_back(fcs[8*j +: 8]);
            if (!good) begin
                p = $urandom_range(n - 4, n - 1);
                frm[p] = frm[p] ^ (8'h01 << $urandom_range(0, 7));
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge CLK) begin
            bus.RX_VALID = 1'b0;
            bus.RX_SOF   = 1'b0;
            bus.RX_EOF   = 1'b0;
            bus.RX_ERR   = 1'b0;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit sof, input bit eof, input bit err);
        @(negedge CLK);
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
        bus.RX_SOF   = sof;
        bus.RX_EOF   = eof;
        bus.RX_ERR   = err;
        byte_q.push_back(b);
        cyc_q.push_back(cyc);
    endtask

    task automatic send_frame(input int gap_max, input int err_at, input bit with_eof);
        for (int j = 0; j < frm.size(); j++) begin
            if (gap_max > 0 && j > 0) idle($urandom_range(0, gap_max));
            drive_byte(frm[j], j == 0, with_eof && (j == frm.size() - 1), j == err_at);
        end
    endtask

    task automatic begin_test(input string tag);
        chk({tag, "_leftover_out"}, 64'(out_q.size()), 0);
        chk({tag, "_leftover_stat"}, 64'(stat_q.size()), 0);
        out_q.delete();
        stat_q.delete();
        byte_q.delete();
        cyc_q.delete();
    endtask

    // Frame occupies byte_q[lo..hi-1]; an aborted frame is terminated by the SOF at byte_q[hi].
    task automatic expect_frame(input string tag, input int lo, input int hi, input bit aborted,
                                input bit exp_phy);
        bq_t   fb;
        int    n;
        int    npay;
        out_t  o;
        stat_t s;
        for (int j = lo; j < hi; j++) fb.push_back(byte_q[j]);
        n    = hi - lo;
        npay = (n > 4) ? n - 4 : 0;
        for (int k = 0; k < npay; k++) begin
            chk({tag, "_out_present"}, 64'(out_q.size() != 0), 1);
            if (out_q.size() == 0) break;
            o = out_q.pop_front();
            chk({tag, "_out_data"}, 64'(o.data), 64'(fb[k]));
            chk({tag, "_out_sof"}, 64'(o.sof), 64'(k == 0));
            chk({tag, "_out_eof"}, 64'(o.eof), 64'(!aborted && k == npay - 1));
            chk({tag, "_out_cycle"}, 64'(o.cyc), 64'(cyc_q[lo + k + 4] + 1));
        end
        chk({tag, "_stat_present"}, 64'(stat_q.size() != 0), 1);
        if (stat_q.size() != 0) begin
            s = stat_q.pop_front();
            chk({tag, "_crc_ok"}, 64'(s.ok), 64'(!aborted && crc_of(fb) == 32'hDEBB_20E3));
            chk({tag, "_len_err"}, 64'(s.len_err), 64'(n < 64 || n > 1518));
            chk({tag, "_phy_err"}, 64'(s.phy), 64'(exp_phy));
            chk({tag, "_length"}, 64'(s.length), 64'(n));
            chk({tag, "_stat_cycle"}, 64'(s.cyc), 64'(aborted ? cyc_q[hi] + 1 : cyc_q[hi - 1] + 1));
        end
    endtask

    initial begin
        int n0;
        RST          = 1'b1;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        bus.RX_SOF   = 1'b0;
        bus.RX_EOF   = 1'b0;
        bus.RX_ERR   = 1'b0;
        idle(3);
        chk("rst_out_valid", 64'(bus.OUT_VALID), 0);
        chk("rst_out_data", 64'(bus.OUT_DATA), 0);
        chk("rst_out_sof_eof", 64'({bus.OUT_SOF, bus.OUT_EOF}), 0);
        chk("rst_stat_valid", 64'(bus.STAT_VALID), 0);
        chk("rst_stat_flags", 64'({bus.STAT_CRC_OK, bus.STAT_LEN_ERR, bus.STAT_PHY_ERR}), 0);
        chk("rst_stat_length", 64'(bus.STAT_LENGTH), 0);
        RST = 1'b0;
        idle(2);

        // 64-byte good frame, back to back
        begin_test("t1");
        build_frame(64, 1'b1);
        frame1 = frm;
        send_frame(0, -1, 1'b1);
        idle(3);
        expect_frame("t1", 0, 64, 1'b0, 1'b0);

        // "123456789" with known FCS, then one FCS bit flipped
        begin_test("t2");
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(0, -1, 1'b1);
        idle(3);
        expect_frame("t2_good", 0, 13, 1'b0, 1'b0);
        begin_test("t2b");
        frm[12] = frm[12] ^ 8'h10;
        send_frame(0, -1, 1'b1);
        idle(3);
        expect_frame("t2_bad", 0, 13, 1'b0, 1'b0);

        // frame 1 again with random gaps
        begin_test("t3");
        frm = frame1;
        send_frame(3, -1, 1'b1);
        idle(3);
        expect_frame("t3", 0, 64, 1'b0, 1'b0);

        // length boundaries: runt, 1-byte, 63, 1518, 1519
        begin_test("t4a");
        build_frame(3, 1'b1);
        send_frame(1, -1, 1'b1);
        idle(3);
        expect_frame("t4_runt", 0, 3, 1'b0, 1'b0);
        begin_test("t4b");
        build_frame(1, 1'b1);
        send_frame(0, -1, 1'b1);
        idle(3);
        expect_frame("t4_one", 0, 1, 1'b0, 1'b0);
        begin_test("t4c");
        build_frame(63, 1'b1);
        send_frame(0, -1, 1'b1);
        idle(3);
        expect_frame("t4_63", 0, 63, 1'b0, 1'b0);
        begin_test("t4d");
        build_frame(1518, 1'b1);
        send_frame(0, -1, 1'b1);
        idle(3);
        expect_frame("t4_1518", 0, 1518, 1'b0, 1'b0);
        begin_test("t4e");
        build_frame(1519, 1'b1);
        send_frame(0, -1, 1'b1);
        idle(3);
        expect_frame("t4_1519", 0, 1519, 1'b0, 1'b0);

        // PHY error mid-frame, then abort by new SOF at byte 20
        begin_test("t5a");
        build_frame(80, 1'b1);
        send_frame(2, 30, 1'b1);
        idle(3);
        expect_frame("t5_err", 0, 80, 1'b0, 1'b1);
        begin_test("t5b");
        build_frame(64, 1'b1);
        frm = frm[0:19];
        send_frame(0, -1, 1'b0);
        build_frame(70, 1'b1);
        send_frame(0, -1, 1'b1);
        idle(3);
        expect_frame("t5_abort", 0, 20, 1'b1, 1'b1);
        expect_frame("t5_new", 20, 90, 1'b0, 1'b0);

        // reset mid-frame
        begin_test("t6");
        build_frame(64, 1'b1);
        frm = frm[0:29];
        send_frame(0, -1, 1'b0);
        @(negedge CLK);
        RST          = 1'b1;
        bus.RX_VALID = 1'b0;
        bus.RX_SOF   = 1'b0;
        @(negedge CLK);
        chk("t6_outputs_zero", 64'({bus.OUT_VALID, bus.OUT_DATA, bus.OUT_SOF, bus.OUT_EOF,
                                    bus.STAT_VALID, bus.STAT_CRC_OK, bus.STAT_LEN_ERR,
                                    bus.STAT_PHY_ERR, bus.STAT_LENGTH}), 0);
        @(negedge CLK);
        RST = 1'b0;
        idle(5);
        chk("t6_no_stat", 64'(stat_q.size()), 0);
        out_q.delete();
        stat_q.delete();
        byte_q.delete();
        cyc_q.delete();
        build_frame(64, 1'b1);
        send_frame(0, -1, 1'b1);
        idle(3);
        expect_frame("t6_after", 0, 64, 1'b0, 1'b0);

        // random lengths, good/bad FCS, random gaps
        for (int r = 0; r < 8; r++) begin
            begin_test("rnd");
            n0 = $urandom_range(4, 90);
            build_frame(n0, 1'($urandom_range(0, 1)));
            send_frame($urandom_range(0, 2), -1, 1'b1);
            idle(3);
            expect_frame("rnd", 0, n0, 1'b0, 1'b0);
        end

        idle(3);
        chk("final_no_extra_out", 64'(out_q.size()), 0);
        chk("final_no_extra_stat", 64'(stat_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
